// File: rtl/systolic_deskew.sv
// rtl/systolic_deskew.sv - realigns staggered systolic-array result lanes into one row per cycle
// Tracks a frame of expected rows, pulses done on the last one, and flags misaligned lane valids.
module systolic_deskew #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ROW_W      = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [ROW_W-1:0]            rows_i,
  input  logic [LANES-1:0]            in_valid_i,
  input  logic [LANES*DATA_WIDTH-1:0] in_data_i,
  output logic                        out_valid_o,
  output logic [LANES*DATA_WIDTH-1:0] out_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int DW = LANES * DATA_WIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [LANES-1:0] al_valid;
  logic [DW-1:0]    al_data;
  logic [DW-1:0]    hold_q;
  logic [ROW_W-1:0] cnt_q;
  logic             err_q;
  logic             row_all;
  logic             row_mixed;
  logic             start_load;
  logic             emit;
  logic             last_row;

  // Lane i gets LANES-i stages so every lane of a row reaches its final stage together.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int DEPTH = LANES - i;
    logic [DEPTH-1:0]      v_q;
    logic [DATA_WIDTH-1:0] d_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v_q <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          d_q[j] <= '0;
        end
      end else begin
        v_q[0] <= in_valid_i[i];
        d_q[0] <= in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 1; j < DEPTH; j++) begin
          v_q[j] <= v_q[j-1];
          d_q[j] <= d_q[j-1];
        end
      end
    end

    assign al_valid[i]                          = v_q[DEPTH-1];
    assign al_data[i*DATA_WIDTH +: DATA_WIDTH]  = d_q[DEPTH-1];
  end

  assign row_all    = &al_valid;
  assign row_mixed  = (|al_valid) && !row_all;
  assign start_load = start_i && (rows_i != '0);
  assign emit       = row_all && (state_q == ACTIVE);
  assign last_row   = (cnt_q == ROW_W'(1));

  // The final stages are the output register; hold_q keeps the last row across gaps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
    end else if (row_all) begin
      hold_q <= al_data;
    end
  end

  assign out_data_o = row_all ? al_data : hold_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (start_load) begin
      cnt_q <= rows_i;
    end else if (emit && !start_i) begin
      cnt_q <= cnt_q - ROW_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (start_load) begin
      err_q <= 1'b0;
    end else if (row_mixed && (state_q == ACTIVE)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (start_i && (rows_i == '0)) begin
          state_d = IDLE;
        end else if (start_load) begin
          state_d = ACTIVE;
        end else if (emit && last_row) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A start in the same cycle as the last row takes over the frame, so done is withheld.
  always_comb begin
    busy_o      = 1'b0;
    out_valid_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      ACTIVE: begin
        busy_o      = 1'b1;
        out_valid_o = row_all;
        done_o      = row_all && last_row && !start_i;
      end
      default: begin
        busy_o      = 1'b0;
        out_valid_o = 1'b0;
        done_o      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_systolic_deskew.sv
// tb/tb_systolic_deskew.sv - self-checking bench for systolic_deskew
// Timeline-scheduled stimulus, directed table, hand sequences and a randomized run against a row-level model.
module tb_systolic_deskew;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int ROW_W = 8;
  localparam int W     = LANES * DW;
  localparam int NC    = 2048;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [ROW_W-1:0] rows_i;
  logic [LANES-1:0] in_valid_i;
  logic [W-1:0]     in_data_i;
  logic             out_valid_o;
  logic [W-1:0]     out_data_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  always #5 clk = ~clk;

  systolic_deskew #(.LANES(LANES), .DATA_WIDTH(DW), .ROW_W(ROW_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .rows_i     (rows_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  // stimulus timeline, indexed by absolute cycle
  logic [LANES-1:0] tv  [NC];
  logic [W-1:0]     td  [NC];
  logic             ts  [NC];
  logic [ROW_W-1:0] tr  [NC];
  logic             trs [NC];

  // observed outputs, indexed by absolute cycle
  logic         ov    [NC];
  logic         odn   [NC];
  logic         obusy [NC];
  logic         oerr  [NC];
  logic [W-1:0] od    [NC];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  logic         m_active = 0;
  logic         m_err    = 0;
  int           m_cnt    = 0;
  logic [W-1:0] m_hold   = '0;
  int           last_rst = -1;

  typedef struct {
    logic do_start;
    int   rows;
    int   nsend;
    int   bad;
    int   e_outs;
    int   e_done;
    logic e_err;
    logic e_busy;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  function automatic logic [W-1:0] mk(input int k);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(32'h0100 * k + i);
    return r;
  endfunction

  task automatic put_row(input int t, input logic [LANES-1:0] mask, input logic [W-1:0] data);
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        tv[t+i][i]          = 1'b1;
        td[t+i][i*DW +: DW] = data[i*DW +: DW];
      end
    end
  endtask

  task automatic sched_start(input int t, input int rows);
    ts[t] = 1'b1;
    tr[t] = ROW_W'(rows);
  endtask

  task automatic tick();
    logic [LANES-1:0] v;
    logic [W-1:0]     row;
    logic             all;
    logic             mixed;
    logic             acc;
    logic             e_valid;
    logic             e_done;
    int               e;
    if (cyc >= NC - 8) begin
      $display("FAIL timeline_overflow cyc=%0d actual=%0d required<%0d", cyc, cyc, NC - 8);
      $fatal(1);
    end
    rst_i      = trs[cyc];
    start_i    = ts[cyc];
    rows_i     = tr[cyc];
    in_valid_i = tv[cyc];
    in_data_i  = td[cyc];
    @(negedge clk);
    ov[cyc]    = out_valid_o;
    odn[cyc]   = done_o;
    obusy[cyc] = busy_o;
    oerr[cyc]  = err_o;
    od[cyc]    = out_data_o;
    // a row is aligned LANES cycles after its lane 0 entered, unless a reset came since
    for (int i = 0; i < LANES; i++) begin
      e = cyc - LANES + i;
      if (e >= 0 && e > last_rst) begin
        v[i]              = tv[e][i];
        row[i*DW +: DW]   = td[e][i*DW +: DW];
      end else begin
        v[i]              = 1'b0;
        row[i*DW +: DW]   = '0;
      end
    end
    all     = &v;
    mixed   = (v != '0) && !all;
    e_valid = m_active && all;
    e_done  = e_valid && (m_cnt == 1) && !ts[cyc];
    if (chk_en) begin
      chk("out_valid", W'(out_valid_o), W'(e_valid));
      chk("out_data", out_data_o, all ? row : m_hold);
      chk("busy", W'(busy_o), W'(m_active));
      chk("done", W'(done_o), W'(e_done));
      chk("err", W'(err_o), W'(m_err));
    end
    @(posedge clk);
    if (trs[cyc]) begin
      m_active = 0;
      m_cnt    = 0;
      m_err    = 0;
      m_hold   = '0;
      last_rst = cyc;
      chk_en   = 1;
    end else begin
      if (all) m_hold = row;
      acc = ts[cyc] && (tr[cyc] != '0);
      if (m_active && mixed) m_err = 1;
      if (acc) m_err = 0;
      if (!m_active) begin
        if (acc) begin
          m_active = 1;
          m_cnt    = int'(tr[cyc]);
        end
      end else if (ts[cyc]) begin
        if (acc) m_cnt = int'(tr[cyc]);
        else m_active = 0;
      end else if (all) begin
        if (m_cnt == 1) m_active = 0;
        m_cnt--;
      end
    end
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic int count_of(input int which, input int a, input int b);
    int n = 0;
    for (int c = a; c < b; c++) begin
      if (which == 0 && ov[c]) n++;
      if (which == 1 && odn[c]) n++;
    end
    return n;
  endfunction

  initial begin
    int t0;
    logic [LANES-1:0] m;
    for (int c = 0; c < NC; c++) begin
      tv[c] = '0; td[c] = '0; ts[c] = 1'b0; tr[c] = '0; trs[c] = 1'b0;
    end
    rst_i = 1'b1; start_i = 1'b0; rows_i = '0; in_valid_i = '0; in_data_i = '0;

    trs[0] = 1'b1;
    trs[1] = 1'b1;
    run(3);

    //          start rows nsend bad outs done err busy
    tbl[0] = '{1'b1, 1, 1, -1, 1, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 3, 3, -1, 3, 1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 2, 3,  0, 2, 1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 4, 2, -1, 2, 0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 2, 5, -1, 2, 1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 0, 2, -1, 0, 0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 0, 2, -1, 0, 0, 1'b0, 1'b0};

    for (int r = 0; r < 7; r++) begin
      t0 = cyc;
      trs[t0] = 1'b1;
      if (tbl[r].do_start) sched_start(t0 + 1, tbl[r].rows);
      for (int k = 0; k < tbl[r].nsend; k++) begin
        m = (k == tbl[r].bad) ? 4'b1011 : 4'b1111;
        put_row(t0 + 2 + k, m, mk(k + 1));
      end
      run(16);
      chk($sformatf("tbl%0d_outs", r), W'(count_of(0, t0 + 1, t0 + 16)), W'(tbl[r].e_outs));
      chk($sformatf("tbl%0d_done", r), W'(count_of(1, t0 + 1, t0 + 16)), W'(tbl[r].e_done));
      chk($sformatf("tbl%0d_err", r), W'(oerr[t0 + 15]), W'(tbl[r].e_err));
      chk($sformatf("tbl%0d_busy", r), W'(obusy[t0 + 15]), W'(tbl[r].e_busy));
    end

    // single-row frame: lane i = 0x10+i, aligned 4 cycles after lane 0
    t0 = cyc;
    trs[t0] = 1'b1;
    sched_start(t0 + 1, 1);
    put_row(t0 + 1, 4'b1111, 64'h0013_0012_0011_0010);
    run(10);
    chk("single_pre", W'(ov[t0 + 4]), W'(0));
    chk("single_valid", W'(ov[t0 + 5]), W'(1));
    chk("single_data", od[t0 + 5], 64'h0013_0012_0011_0010);
    chk("single_done", W'(odn[t0 + 5]), W'(1));
    chk("single_busy_hi", W'(obusy[t0 + 5]), W'(1));
    chk("single_busy_lo", W'(obusy[t0 + 6]), W'(0));

    // restart after two rows: third row uncounted, done two rows later
    t0 = cyc;
    trs[t0] = 1'b1;
    sched_start(t0 + 1, 4);
    for (int k = 0; k < 6; k++) put_row(t0 + 2 + k, 4'b1111, mk(k));
    sched_start(t0 + 8, 2);
    run(16);
    chk("restart_row_out", W'(ov[t0 + 8]), W'(1));
    chk("restart_no_done", W'(odn[t0 + 8]), W'(0));
    chk("restart_busy", W'(obusy[t0 + 9]), W'(1));
    chk("restart_mid_done", W'(odn[t0 + 9]), W'(0));
    chk("restart_done", W'(odn[t0 + 10]), W'(1));
    chk("restart_data", od[t0 + 10], mk(4));
    chk("restart_after", W'(ov[t0 + 11]), W'(0));
    chk("restart_idle", W'(obusy[t0 + 11]), W'(0));

    // abort with rows=0 while a row is being emitted
    t0 = cyc;
    trs[t0] = 1'b1;
    sched_start(t0 + 1, 3);
    for (int k = 0; k < 3; k++) put_row(t0 + 2 + k, 4'b1111, mk(k + 7));
    sched_start(t0 + 7, 0);
    run(14);
    chk("abort_row_out", W'(ov[t0 + 7]), W'(1));
    chk("abort_busy", W'(obusy[t0 + 8]), W'(0));
    chk("abort_dropped", W'(ov[t0 + 8]), W'(0));
    chk("abort_no_done", W'(count_of(1, t0 + 1, t0 + 14)), W'(0));

    // reset mid-frame with rows in flight and err set
    t0 = cyc;
    trs[t0] = 1'b1;
    sched_start(t0 + 1, 4);
    put_row(t0 + 2, 4'b1011, mk(3));
    for (int k = 1; k < 4; k++) put_row(t0 + 2 + k, 4'b1111, mk(k));
    trs[t0 + 7] = 1'b1;
    run(16);
    chk("rst_pre_err", W'(oerr[t0 + 7]), W'(1));
    chk("rst_pre_data", od[t0 + 7], mk(1));
    chk("rst_valid", W'(ov[t0 + 8]), W'(0));
    chk("rst_data", od[t0 + 8], '0);
    chk("rst_busy", W'(obusy[t0 + 8]), W'(0));
    chk("rst_done", W'(odn[t0 + 8]), W'(0));
    chk("rst_err", W'(oerr[t0 + 8]), W'(0));
    chk("rst_flushed", W'(count_of(0, t0 + 8, t0 + 16)), W'(0));

    // randomized traffic against the model
    t0 = cyc;
    trs[t0] = 1'b1;
    for (int c = t0 + 1; c < t0 + 1200; c++) begin
      if ($urandom_range(15) == 0) sched_start(c, ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 5));
      if ($urandom_range(3) != 0) begin
        m = ($urandom_range(9) == 0) ? LANES'($urandom) : 4'b1111;
        put_row(c, m, {$urandom, $urandom});
      end
      if ($urandom_range(199) == 0) trs[c] = 1'b1;
    end
    run(1210);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
